// File: rtl/tlb_refill_unit.sv
// tlb_refill_unit: fully associative TLB in front of the memory ports.
// A request is looked up against all valid entries. On a miss the unit
// reads one PTE from a single-level page table in synchronous RAM, refills
// an entry and returns the translation, or reports a fault if the PTE is
// invalid.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_vaddr only needs to be stable on that edge.
// resp_valid is a one-cycle pulse. resp_paddr and resp_fault hold their
// values until the next response.
module tlb_refill_unit #(
  parameter int          ENTRIES = 4,
  parameter logic [15:0] PTBR    = 16'h0100
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        req_valid,
  input  logic [15:0] req_vaddr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_paddr,
  output logic        resp_fault,
  input  logic        flush,
  output logic        pt_rd_en,
  output logic [15:0] pt_addr,
  input  logic [15:0] pt_rd_data,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt,
  output logic [1:0]  dbg_state_o
);

  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_WALK   = 2'd2,
    S_WAIT   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         vaddr_q, vaddr_d;
  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [7:0]          vpn_q [ENTRIES];
  logic [7:0]          vpn_d [ENTRIES];
  logic [7:0]          ppn_q [ENTRIES];
  logic [7:0]          ppn_d [ENTRIES];
  logic [IW-1:0]       rr_q, rr_d;
  logic                pflush_q, pflush_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_fault_q, resp_fault_d;
  logic [15:0]         resp_paddr_q, resp_paddr_d;
  logic                pt_rd_en_q, pt_rd_en_d;
  logic [15:0]         pt_addr_q, pt_addr_d;
  logic [15:0]         hit_cnt_q, hit_cnt_d;
  logic [15:0]         miss_cnt_q, miss_cnt_d;

  logic                hit;
  logic [7:0]          hit_ppn;
  logic                have_free;
  logic [IW-1:0]       free_idx;
  logic [IW-1:0]       victim;

  // PTE bits [14:8] carry no meaning for this unit.
  logic                pte_unused;
  assign pte_unused = ^pt_rd_data[14:8];

  // Requests are taken only in IDLE, and never while a flush is being applied.
  assign req_ready   = (state_q == S_IDLE) & ~flush & ~pflush_q;

  assign resp_valid  = resp_valid_q;
  assign resp_fault  = resp_fault_q;
  assign resp_paddr  = resp_paddr_q;
  assign pt_rd_en    = pt_rd_en_q;
  assign pt_addr     = pt_addr_q;
  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;
  assign dbg_state_o = state_q;

  // Associative match of the latched VPN, plus the lowest-index free slot.
  always_comb begin
    hit       = 1'b0;
    hit_ppn   = 8'h00;
    have_free = 1'b0;
    free_idx  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (vpn_q[i] == vaddr_q[15:8])) begin
        hit     = 1'b1;
        hit_ppn = ppn_q[i];
      end
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        have_free = 1'b1;
        free_idx  = IW'(i);
      end
    end
    victim = have_free ? free_idx : rr_q;
  end

  // Next-state and registered-output logic for the translation FSM.
  always_comb begin
    state_d      = state_q;
    vaddr_d      = vaddr_q;
    valid_d      = valid_q;
    vpn_d        = vpn_q;
    ppn_d        = ppn_q;
    rr_d         = rr_q;
    pflush_d     = pflush_q;
    resp_valid_d = 1'b0;
    resp_fault_d = resp_fault_q;
    resp_paddr_d = resp_paddr_q;
    pt_rd_en_d   = 1'b0;
    pt_addr_d    = pt_addr_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;

    // A flush seen while busy is deferred so the in-flight fill is dropped too.
    if ((state_q != S_IDLE) && flush) begin
      pflush_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (flush || pflush_q) begin
          valid_d  = '0;
          rr_d     = '0;
          pflush_d = 1'b0;
        end else if (req_valid) begin
          vaddr_d = req_vaddr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b0;
          resp_paddr_d = {hit_ppn, vaddr_q[7:0]};
          if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
          state_d = S_IDLE;
        end else begin
          pt_rd_en_d = 1'b1;
          pt_addr_d  = PTBR + {8'h00, vaddr_q[15:8]};
          state_d    = S_WALK;
        end
      end
      S_WALK: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
        resp_valid_d = 1'b1;
        if (pt_rd_data[15]) begin
          valid_d[victim] = 1'b1;
          vpn_d[victim]   = vaddr_q[15:8];
          ppn_d[victim]   = pt_rd_data[7:0];
          if (!have_free) rr_d = rr_q + IW'(1);
          resp_fault_d = 1'b0;
          resp_paddr_d = {pt_rd_data[7:0], vaddr_q[7:0]};
        end else begin
          resp_fault_d = 1'b1;
          resp_paddr_d = 16'h0000;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any walk in progress.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= S_IDLE;
      vaddr_q      <= 16'h0000;
      valid_q      <= '0;
      vpn_q        <= '{default: 8'h00};
      ppn_q        <= '{default: 8'h00};
      rr_q         <= '0;
      pflush_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_paddr_q <= 16'h0000;
      pt_rd_en_q   <= 1'b0;
      pt_addr_q    <= 16'h0000;
      hit_cnt_q    <= 16'h0000;
      miss_cnt_q   <= 16'h0000;
    end else begin
      state_q      <= state_d;
      vaddr_q      <= vaddr_d;
      valid_q      <= valid_d;
      vpn_q        <= vpn_d;
      ppn_q        <= ppn_d;
      rr_q         <= rr_d;
      pflush_q     <= pflush_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_paddr_q <= resp_paddr_d;
      pt_rd_en_q   <= pt_rd_en_d;
      pt_addr_q    <= pt_addr_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

endmodule
